agc_sequencer: RTL and testbench

AGC_SEQUENCER -- requirements
Module: agc_sequencer

---
 rtl/agc_pkg.sv | 26 ++
 rtl/agc_window_meas.sv | 56 +++++
 rtl/agc_sequencer.sv | 174 +++++++++++++++++
 tb/tb_agc_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : agc_pkg
// Brief    : Shared AGC sequencer state encoding and parameter defaults.
// Revision : 1.0
// ============================================================================
package agc_pkg;

    localparam int unsigned c_SETTLE_CYCLES_DEF  = 16;
    localparam int unsigned c_MEAS_CYCLES_DEF    = 64;
    localparam int unsigned c_RELOCK_WINDOWS_DEF = 4;
    localparam int unsigned c_MAX_STEPS_DEF      = 8;

    localparam int unsigned c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] agc_state_t;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RESTART = 3'd1;
    localparam logic [2:0] c_ST_SETTLE  = 3'd2;
    localparam logic [2:0] c_ST_MEASURE = 3'd3;
    localparam logic [2:0] c_ST_STEP    = 3'd4;
    localparam logic [2:0] c_ST_CHECK   = 3'd5;
    localparam logic [2:0] c_ST_LOCKED  = 3'd6;

endpackage
`default_nettype wire

// File: rtl/agc_window_meas.sv
`default_nettype none
// ============================================================================
// Module   : agc_window_meas
// Brief    : Detector measurement window: length counter plus over/reached flags.
// Revision : 1.0
// ============================================================================
module agc_window_meas
    import agc_pkg::*;
#(
    parameter int unsigned MEAS_CYCLES = c_MEAS_CYCLES_DEF
) (
    input  logic clk,
    input  logic RESETn,
    input  logic i_start,
    input  logic i_run,
    input  logic i_peak_hi,
    input  logic i_peak_lo,
    output logic o_end,
    output logic o_over,
    output logic o_reached
);

    localparam int unsigned     c_MW   = $clog2(MEAS_CYCLES) + 1;
    localparam logic [c_MW-1:0] c_LAST = c_MW'(MEAS_CYCLES - 1);

    logic [c_MW-1:0] r_cnt;
    logic            r_over;
    logic            r_reached;

    // i_start arrives in the cycle before a window, so the first window cycle
    // already sees a cleared counter; it wins over i_run for back-to-back use.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_cnt     <= '0;
            r_over    <= 1'b0;
            r_reached <= 1'b0;
        end else if (i_start) begin
            r_cnt     <= '0;
            r_over    <= 1'b0;
            r_reached <= 1'b0;
        end else if (i_run) begin
            if (r_cnt != c_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_over    <= r_over | i_peak_hi;
            r_reached <= r_reached | i_peak_lo;
        end
    end

    // Flags fold in the current sample so the final window cycle is counted.
    assign o_end     = i_run && (r_cnt == c_LAST);
    assign o_over    = r_over | i_peak_hi;
    assign o_reached = r_reached | i_peak_lo;

endmodule
`default_nettype wire

// File: rtl/agc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : agc_sequencer
// Brief    : AGC acquisition/tracking FSM driving a gain binary-search block.
// Revision : 1.0
// ============================================================================
module agc_sequencer
    import agc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = c_SETTLE_CYCLES_DEF,
    parameter int unsigned MEAS_CYCLES    = c_MEAS_CYCLES_DEF,
    parameter int unsigned RELOCK_WINDOWS = c_RELOCK_WINDOWS_DEF,
    parameter int unsigned MAX_STEPS      = c_MAX_STEPS_DEF
) (
    input  logic clk,
    input  logic RESETn,
    input  logic enable,
    input  logic peak_hi,
    input  logic peak_lo,
    input  logic search_done,
    output logic adjust,
    output logic up_dn,
    output logic search_rst_n,
    output logic det_clear,
    output logic locked,
    output logic timeout
);

    localparam int unsigned     c_SW          = $clog2(SETTLE_CYCLES) + 1;
    localparam int unsigned     c_RW          = $clog2(RELOCK_WINDOWS) + 1;
    localparam int unsigned     c_TW          = $clog2(MAX_STEPS) + 1;
    localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);
    localparam logic [c_RW-1:0] c_OOR_LAST    = c_RW'(RELOCK_WINDOWS - 1);
    localparam logic [c_TW-1:0] c_STEP_MAX    = c_TW'(MAX_STEPS);

    agc_state_t      r_state;
    agc_state_t      w_next;
    logic [c_SW-1:0] r_settle_cnt;
    logic [c_TW-1:0] r_step_cnt;
    logic [c_RW-1:0] r_oor_cnt;
    logic            r_en_d;
    logic            r_adjust;
    logic            r_up_dn;
    logic            r_search_rst_n;
    logic            r_det_clear;
    logic            r_locked;
    logic            r_timeout;

    logic            w_settle_done;
    logic            w_win_end;
    logic            w_over;
    logic            w_reached;
    logic            w_oor;
    logic            w_start;
    logic            w_run;
    logic            w_timeout_set;

    assign w_settle_done = (r_state == c_ST_SETTLE) && (r_settle_cnt == c_SETTLE_LAST);
    assign w_oor         = w_over | ~w_reached;
    assign w_run         = (r_state == c_ST_MEASURE) || (r_state == c_ST_LOCKED);
    assign w_start       = ((w_next == c_ST_MEASURE) && (r_state != c_ST_MEASURE)) ||
                           ((w_next == c_ST_LOCKED) && ((r_state != c_ST_LOCKED) || w_win_end));

    agc_window_meas #(
        .MEAS_CYCLES (MEAS_CYCLES)
    ) u_meas (
        .clk       (clk),
        .RESETn    (RESETn),
        .i_start   (w_start),
        .i_run     (w_run),
        .i_peak_hi (peak_hi),
        .i_peak_lo (peak_lo),
        .o_end     (w_win_end),
        .o_over    (w_over),
        .o_reached (w_reached)
    );

    always_comb begin
        w_next        = r_state;
        w_timeout_set = 1'b0;
        if (!enable) begin
            w_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:    w_next = c_ST_RESTART;
                c_ST_RESTART: w_next = c_ST_SETTLE;
                c_ST_SETTLE:  if (w_settle_done) w_next = c_ST_MEASURE;
                c_ST_MEASURE: if (w_win_end) w_next = c_ST_STEP;
                c_ST_STEP:    w_next = c_ST_CHECK;
                c_ST_CHECK: begin
                    if (search_done) begin
                        w_next = c_ST_LOCKED;
                    end else if (r_step_cnt == c_STEP_MAX) begin
                        w_next        = c_ST_RESTART;
                        w_timeout_set = 1'b1;
                    end else begin
                        w_next = c_ST_SETTLE;
                    end
                end
                c_ST_LOCKED: begin
                    if (w_win_end && w_oor && (r_oor_cnt == c_OOR_LAST)) begin
                        w_next = c_ST_RESTART;
                    end
                end
                default:      w_next = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_state        <= c_ST_IDLE;
            r_settle_cnt   <= '0;
            r_step_cnt     <= '0;
            r_oor_cnt      <= '0;
            r_en_d         <= 1'b0;
            r_adjust       <= 1'b0;
            r_up_dn        <= 1'b0;
            r_search_rst_n <= 1'b1;
            r_det_clear    <= 1'b0;
            r_locked       <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_en_d  <= enable;

            if ((r_state == c_ST_SETTLE) && !w_settle_done) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end else begin
                r_settle_cnt <= '0;
            end

            if ((r_state == c_ST_RESTART) || (r_state == c_ST_IDLE)) begin
                r_step_cnt <= '0;
            end else if ((r_state == c_ST_STEP) && (r_step_cnt != c_STEP_MAX)) begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end

            if ((r_state != c_ST_LOCKED) || (w_win_end && !w_oor)) begin
                r_oor_cnt <= '0;
            end else if (w_win_end && (r_oor_cnt != c_OOR_LAST)) begin
                r_oor_cnt <= r_oor_cnt + 1'b1;
            end

            // Outputs are registered from the next state so each one tracks
            // its state exactly, with no input-to-output combinational path.
            r_adjust       <= (w_next == c_ST_STEP);
            r_search_rst_n <= (w_next != c_ST_RESTART);
            r_det_clear    <= (w_next == c_ST_SETTLE);
            r_locked       <= (w_next == c_ST_LOCKED);

            if (w_next == c_ST_STEP) begin
                r_up_dn <= ~w_over;
            end else if (w_next == c_ST_IDLE) begin
                r_up_dn <= 1'b0;
            end

            if (enable && !r_en_d) begin
                r_timeout <= 1'b0;
            end else if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign adjust       = r_adjust;
    assign up_dn        = r_up_dn;
    assign search_rst_n = r_search_rst_n;
    assign det_clear    = r_det_clear;
    assign locked       = r_locked;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_agc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_agc_sequencer
// Brief    : Self-checking bench for agc_sequencer with a gain-search model.
// Revision : 1.0
// ============================================================================
module tb_agc_sequencer;

    localparam int S  = 16;
    localparam int M  = 64;
    localparam int R  = 4;
    localparam int MX = 8;

    logic clk          = 1'b0;
    logic RESETn       = 1'b1;
    logic enable       = 1'b0;
    logic peak_hi      = 1'b0;
    logic peak_lo      = 1'b0;
    logic search_done  = 1'b0;
    logic adjust;
    logic up_dn;
    logic search_rst_n;
    logic det_clear;
    logic locked;
    logic timeout;

    int   n_pass       = 0;
    int   n_total      = 0;
    int   cyc          = 0;
    int   settle_start = 0;
    int   adj_count    = 0;
    int   rst_pulses   = 0;
    int   rst_len      = 0;
    int   sm_cnt       = 0;
    int   sm_target    = 1000;
    logic prev_det     = 1'b0;
    logic exp_up;
    logic exp_q[$];

    typedef struct {
        int   mode;    // 0 none, 1 steady hi, 2 hi on last window cycle, 3 hi only in settle
        logic lo;
        logic exp_up;
    } vec_t;
    vec_t vecs[5];

    agc_sequencer #(
        .SETTLE_CYCLES  (S),
        .MEAS_CYCLES    (M),
        .RELOCK_WINDOWS (R),
        .MAX_STEPS      (MX)
    ) dut (
        .clk          (clk),
        .RESETn       (RESETn),
        .enable       (enable),
        .peak_hi      (peak_hi),
        .peak_lo      (peak_lo),
        .search_done  (search_done),
        .adjust       (adjust),
        .up_dn        (up_dn),
        .search_rst_n (search_rst_n),
        .det_clear    (det_clear),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Gain binary-search model: converges after sm_target adjust pulses.
    always @(posedge clk or negedge RESETn) begin
        if (!RESETn || !search_rst_n) begin
            sm_cnt      <= 0;
            search_done <= 1'b0;
        end else if (adjust) begin
            sm_cnt      <= sm_cnt + 1;
            search_done <= (sm_cnt + 1 >= sm_target);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return det_clear;
            1:       return adjust;
            2:       return locked;
            3:       return timeout;
            default: return search_rst_n;
        endcase
    endfunction

    task automatic wait_sig(input int s, input logic v, input int budget, input string name);
        int i = 0;
        while (sig(s) !== v && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (sig(s) !== v) check({"wait_", name}, int'(sig(s)), int'(v));
    endtask

    // Scoreboard monitor: every adjust pulse pops one expected direction.
    always @(negedge clk) begin
        cyc++;
        if (det_clear && !prev_det) settle_start = cyc;
        prev_det = det_clear;
        if (adjust) begin
            adj_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_adjust", int'(adjust), 0);
            end else begin
                exp_up = exp_q.pop_front();
                check("up_dn", int'(up_dn), int'(exp_up));
                check("settle_to_adjust", cyc - settle_start, S + M);
            end
        end
        if (!search_rst_n) begin
            rst_len++;
        end else if (rst_len > 0) begin
            check("rst_pulse_width", rst_len, 1);
            rst_pulses++;
            rst_len = 0;
        end
    end

    initial begin
        int   base_adj;
        int   base_rst;
        int   n;
        logic [7:0] pat_hi;
        logic [7:0] pat_lo;

        vecs[0] = '{0, 1'b0, 1'b1};
        vecs[1] = '{0, 1'b1, 1'b1};
        vecs[2] = '{1, 1'b1, 1'b0};
        vecs[3] = '{2, 1'b0, 1'b0};
        vecs[4] = '{3, 1'b0, 1'b1};

        // Asynchronous reset with no clock edge yet
        #1 RESETn = 1'b0;
        #1;
        check("rst_adjust",       int'(adjust),       0);
        check("rst_up_dn",        int'(up_dn),        0);
        check("rst_search_rst_n", int'(search_rst_n), 1);
        check("rst_det_clear",    int'(det_clear),    0);
        check("rst_locked",       int'(locked),       0);
        check("rst_timeout",      int'(timeout),      0);
        @(negedge clk);
        RESETn = 1'b1;
        @(negedge clk);

        // Table: one vector per acquisition step, search never converges
        sm_target = 1000;
        enable    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_sig(0, 1'b1, 40, "settle");
            peak_hi = (vecs[k].mode == 3);
            peak_lo = 1'b0;
            exp_q.push_back(vecs[k].exp_up);
            wait_sig(0, 1'b0, S + 4, "measure");
            peak_hi = (vecs[k].mode == 1);
            peak_lo = vecs[k].lo;
            if (vecs[k].mode == 2) begin
                repeat (M - 1) @(negedge clk);
                peak_hi = 1'b1;
                @(negedge clk);
                peak_hi = 1'b0;
            end
            wait_sig(1, 1'b1, M + 4, "adjust");
            peak_hi = 1'b0;
            peak_lo = 1'b0;
        end
        enable = 1'b0;
        @(negedge clk);
        check("idle_locked",    int'(locked),       0);
        check("idle_det_clear", int'(det_clear),    0);
        check("idle_rst_n",     int'(search_rst_n), 1);
        @(negedge clk);

        // Never converging: MAX_STEPS up steps, then timeout and a restart
        base_adj = adj_count;
        base_rst = rst_pulses;
        for (int k = 0; k < MX; k++) exp_q.push_back(1'b1);
        enable = 1'b1;
        wait_sig(3, 1'b1, MX * (S + M + 2) + 20, "timeout");
        check("to_adjusts", adj_count - base_adj, MX);
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        check("to_rst_pulses", rst_pulses - base_rst, 2);
        @(negedge clk);
        @(negedge clk);
        check("to_sticky", int'(timeout), 1);
        enable = 1'b1;
        @(negedge clk);
        check("to_clear_on_enable", int'(timeout), 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // Steady peak_hi: six down steps, lock, then relock after R windows
        sm_target = 6;
        peak_hi   = 1'b1;
        peak_lo   = 1'b1;
        base_adj  = adj_count;
        for (int k = 0; k < 6; k++) exp_q.push_back(1'b0);
        enable = 1'b1;
        wait_sig(2, 1'b1, 6 * (S + M + 2) + 20, "lock");
        check("acq_adjusts", adj_count - base_adj, 6);
        check("acq_timeout", int'(timeout), 0);
        n = 0;
        while (locked && n < R * M + 8) begin
            n++;
            @(negedge clk);
        end
        check("locked_cycles", n, R * M);
        check("relock_rst_n", int'(search_rst_n), 0);
        enable  = 1'b0;
        peak_hi = 1'b0;
        peak_lo = 1'b0;
        repeat (3) @(negedge clk);

        // Out-of-range x3, in-range, out-of-range x4: drop only on the last
        sm_target = 1;
        peak_lo   = 1'b1;
        exp_q.push_back(1'b1);
        enable = 1'b1;
        wait_sig(2, 1'b1, S + M + 20, "lock2");
        pat_hi = 8'b1111_0000;
        pat_lo = 8'b1111_1000;
        for (int w = 0; w < 8; w++) begin
            check($sformatf("hold_w%0d", w), int'(locked), 1);
            peak_hi = pat_hi[w];
            peak_lo = pat_lo[w];
            repeat (M) @(negedge clk);
        end
        check("drop_locked", int'(locked), 0);
        check("drop_rst_n", int'(search_rst_n), 0);
        enable  = 1'b0;
        peak_hi = 1'b0;
        peak_lo = 1'b0;
        repeat (3) @(negedge clk);

        // Abort mid-MEASURE: no adjust, no extra restart pulse
        base_adj = adj_count;
        base_rst = rst_pulses;
        sm_target = 1000;
        enable = 1'b1;
        wait_sig(0, 1'b1, 40, "abort_settle");
        wait_sig(0, 1'b0, S + 4, "abort_measure");
        repeat (M / 2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_locked", int'(locked), 0);
        check("abort_rst_n", int'(search_rst_n), 1);
        repeat (S + M + 10) @(negedge clk);
        check("abort_no_adjust", adj_count - base_adj, 0);
        check("abort_rst_pulses", rst_pulses - base_rst, 1);

        // Reset asserted between edges while in STEP
        exp_q.push_back(1'b1);
        enable = 1'b1;
        wait_sig(1, 1'b1, S + M + 20, "adjust_rst");
        #1 RESETn = 1'b0;
        #1;
        check("areset_adjust",       int'(adjust),       0);
        check("areset_up_dn",        int'(up_dn),        0);
        check("areset_search_rst_n", int'(search_rst_n), 1);
        check("areset_det_clear",    int'(det_clear),    0);
        check("areset_locked",       int'(locked),       0);
        @(negedge clk);
        RESETn = 1'b1;
        @(negedge clk);
        check("release_restart", int'(search_rst_n), 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
